// File: rtl/psk31_bpsk_demod.sv
// psk31_bpsk_demod: coherent BPSK mixer with per-symbol integrate-and-dump and differential phase decision
module psk31_bpsk_demod #(
  parameter int N_IN = 16,
  parameter int N_LO = 16,
  parameter int SAMPLES_PER_SYM = 256,
  parameter int CNT_W = 9,
  parameter int ACC_W = N_IN + N_LO + CNT_W,
  parameter int DEC_W = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] sample_in,
  input  logic            sample_valid,
  input  logic [N_LO-1:0] lo_i,
  input  logic [N_LO-1:0] lo_q,
  input  logic            sym_align,
  output logic            bit_out,
  output logic            bit_valid,
  input  logic            bit_ready,
  output logic            overrun
);
  localparam int PW = N_IN + N_LO;
  localparam int MW = 2 * DEC_W;
  localparam int DW = MW + 1;
  typedef enum logic {ACQ, RUN} state_t;
  state_t state, state_nx;
  logic signed [PW-1:0] p_i, p_q;
  logic signed [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q;
  logic signed [DEC_W-1:0] cur_i, cur_q, prev_i, prev_q;
  logic signed [MW-1:0] m_i, m_q;
  logic signed [DW-1:0] dot;
  logic [CNT_W-1:0] count;
  logic pv, dump, dv, last;
  assign sum_i = acc_i + ACC_W'(p_i);
  assign sum_q = acc_q + ACC_W'(p_q);
  assign last = count == CNT_W'(SAMPLES_PER_SYM - 1);
  assign m_i = MW'(cur_i) * MW'(prev_i);
  assign m_q = MW'(cur_q) * MW'(prev_q);
  always_comb begin
    state_nx = state;
    if (sym_align) state_nx = ACQ;
    else if (dump) state_nx = RUN;
  end
  always_ff @(posedge clk) state <= !rst ? ACQ : state_nx;
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_i <= '0;
      p_q <= '0;
      pv <= 1'b0;
      acc_i <= '0;
      acc_q <= '0;
      count <= '0;
      cur_i <= '0;
      cur_q <= '0;
      prev_i <= '0;
      prev_q <= '0;
      dump <= 1'b0;
      dot <= '0;
      dv <= 1'b0;
      bit_out <= 1'b0;
      bit_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pv <= sample_valid;
      if (sample_valid) begin
        p_i <= PW'($signed(sample_in)) * PW'($signed(lo_i));
        p_q <= PW'($signed(sample_in)) * PW'($signed(lo_q));
      end
      dump <= 1'b0;
      dv <= 1'b0;
      // realignment drops the in-flight product and any dump/decision still in the pipe
      if (sym_align) begin
        acc_i <= '0;
        acc_q <= '0;
        count <= '0;
      end else begin
        if (pv && last) begin
          cur_i <= sum_i[ACC_W-1 -: DEC_W];
          cur_q <= sum_q[ACC_W-1 -: DEC_W];
          acc_i <= '0;
          acc_q <= '0;
          count <= '0;
          dump <= 1'b1;
        end else if (pv) begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          count <= count + 1'b1;
        end
        if (dump) begin
          prev_i <= cur_i;
          prev_q <= cur_q;
        end
        if (dump && state == RUN) begin
          dot <= DW'(m_i) + DW'(m_q);
          dv <= 1'b1;
        end
      end
      if (dv && !sym_align && (!bit_valid || bit_ready)) begin
        bit_out <= dot >= DW'(0);
        bit_valid <= 1'b1;
      end else if (dv && !sym_align) overrun <= 1'b1;
      else if (bit_valid && bit_ready) bit_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_psk31_bpsk_demod.sv
// tb_psk31_bpsk_demod: random and directed stimulus checked against a symbol-level reference model
module tb_psk31_bpsk_demod;
  localparam int SPS = 16, ACC_W = 36, DEC_W = 18;
  logic clk = 1'b0, rst = 1'b0;
  logic [15:0] sample_in = '0, lo_i = 16'd16384, lo_q = '0;
  logic sample_valid = 1'b0, sym_align = 1'b0, bit_ready = 1'b0;
  logic bit_out, bit_valid, overrun;
  int total = 0, bad = 0, cyc = 0;
  bit chk_en = 1'b0;
  longint si, sq, ci, cq, pi_m, pq_m;
  int n;
  bit acq, m_bo, m_bv, m_ovr, b;
  int pend_due[$];
  bit pend_bit[$];
  bit rx[$];

  psk31_bpsk_demod #(.SAMPLES_PER_SYM(SPS), .CNT_W(4), .ACC_W(ACC_W), .DEC_W(DEC_W)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid), .lo_i(lo_i),
    .lo_q(lo_q), .sym_align(sym_align), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .overrun(overrun));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // model: whole-symbol sums, decision due 3 edges after the symbol's last sample
  always @(posedge clk) begin
    if (!rst) begin
      si = 0; sq = 0; n = 0; acq = 0; m_bo = 0; m_bv = 0; m_ovr = 0;
      pend_due.delete(); pend_bit.delete();
    end else begin
      if (sym_align) begin
        pend_due.delete(); pend_bit.delete();
      end
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        b = pend_bit.pop_front();
        void'(pend_due.pop_front());
        if (!m_bv || bit_ready) begin m_bo = b; m_bv = 1; end
        else m_ovr = 1;
      end else if (m_bv && bit_ready) m_bv = 0;
      if (sym_align) begin si = 0; sq = 0; n = 0; acq = 0; end
      if (sample_valid) begin
        si += longint'($signed(sample_in)) * longint'($signed(lo_i));
        sq += longint'($signed(sample_in)) * longint'($signed(lo_q));
        n++;
        if (n == SPS) begin
          ci = si >>> (ACC_W - DEC_W);
          cq = sq >>> (ACC_W - DEC_W);
          if (acq) begin
            pend_due.push_back(cyc + 3);
            pend_bit.push_back((ci * pi_m + cq * pq_m) >= 0);
          end
          pi_m = ci; pq_m = cq; acq = 1; si = 0; sq = 0; n = 0;
        end
      end
    end
    cyc++;
  end

  always @(posedge clk) if (rst && bit_valid && bit_ready) rx.push_back(bit_out);

  always @(negedge clk) if (chk_en) begin
    check("bit_valid", bit_valid, m_bv);
    check("bit_out", bit_out, m_bo);
    check("overrun", overrun, m_ovr);
  end

  task automatic step(input logic v, input int s, input logic al);
    sample_valid = v; sample_in = 16'(s); sym_align = al;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 0, 1'b0);
  endtask

  task automatic sym(input int s, input int gap);
    for (int i = 0; i < SPS; i++) begin
      step(1'b1, s, 1'b0);
      idle(gap);
    end
  endtask

  task automatic do_reset;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_ready = 1'($urandom);
      step(1'($urandom), int'($urandom), 1'($urandom));
    end
    check("rst_bit_valid", bit_valid, 1'b0);
    check("rst_bit_out", bit_out, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b1;
    chk_en = 1'b1;
    rx.delete();
  endtask

  initial begin
    do_reset;
    bit_ready = 1'b1;
    sym(8192, 0);
    sym(8192, 0);
    step(1'b1, 8192, 1'b0);
    step(1'b1, 8192, 1'b0);
    check("lat_before_k3", bit_valid, 1'b0);
    step(1'b1, 8192, 1'b0);
    check("lat_at_k3", bit_valid, 1'b1);
    check("lat_bit", bit_out, 1'b1);
    for (int i = 0; i < SPS - 3; i++) step(1'b1, 8192, 1'b0);
    idle(4);
    check("const_nbits", rx.size(), 2);
    check("const_b0", rx[0], 1'b1);
    check("const_b1", rx[1], 1'b1);

    do_reset;
    bit_ready = 1'b1;
    sym(8192, 0); sym(8192, 0); sym(-8192, 0); sym(-8192, 0);
    idle(4);
    check("rev_nbits", rx.size(), 3);
    check("rev_b0", rx[0], 1'b1);
    check("rev_b1", rx[1], 1'b0);
    check("rev_b2", rx[2], 1'b1);

    do_reset;
    bit_ready = 1'b0;
    sym(8192, 0); sym(8192, 0); sym(8192, 0);
    idle(4);
    check("bp_held", bit_valid, 1'b1);
    check("bp_overrun", overrun, 1'b1);
    bit_ready = 1'b1;
    step(1'b0, 0, 1'b0);
    bit_ready = 1'b0;
    check("bp_consumed", bit_valid, 1'b0);
    check("bp_nbits", rx.size(), 1);
    idle(2);
    check("bp_sticky", overrun, 1'b1);

    do_reset;
    bit_ready = 1'b1;
    sym(8192, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 8192, 1'b0);
    step(1'b1, 8192, 1'b1);
    for (int i = 0; i < SPS - 1; i++) step(1'b1, 8192, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, -8192, 1'b0);
    check("align_no_partial", rx.size(), 0);
    for (int i = 0; i < SPS - 4; i++) step(1'b1, -8192, 1'b0);
    idle(4);
    check("align_nbits", rx.size(), 1);
    check("align_bit", rx[0], 1'b0);

    do_reset;
    bit_ready = 1'b1;
    sym(0, 0); sym(0, 0);
    idle(4);
    check("zero_nbits", rx.size(), 1);
    check("zero_bit", rx[0], 1'b1);

    do_reset;
    bit_ready = 1'b1;
    sym(8192, 2); sym(8192, 2); sym(-8192, 2); sym(-8192, 2);
    idle(4);
    check("gap_nbits", rx.size(), 3);
    check("gap_b0", rx[0], 1'b1);
    check("gap_b1", rx[1], 1'b0);
    check("gap_b2", rx[2], 1'b1);

    do_reset;
    begin
      bit sgn = 1'b0;
      for (int i = 0; i < 6000; i++) begin
        if ($urandom_range(0, 19) == 0) sgn = ~sgn;
        if ($urandom_range(0, 2999) == 0) do_reset;
        bit_ready = $urandom_range(0, 9) < 7;
        lo_i = (i < 3000) ? 16'd16384 : 16'($urandom);
        lo_q = (i < 1500) ? 16'd0 : 16'($urandom);
        step($urandom_range(0, 3) != 0,
             sgn ? -int'($urandom_range(0, 30000)) : int'($urandom_range(0, 30000)),
             $urandom_range(0, 299) == 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
